// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-master arbiter for a single shared SRAM port
//
// Shares one SRAM port between an instruction fetch master and a data
// load/store master. Each access holds the SRAM port for WAIT_STATES+1 cycles,
// then spends one DONE cycle. The requester's ack pulses in the cycle after
// DONE, which is also the IDLE cycle in which the next request can be granted.
//
// Parameters:
//   WAIT_STATES   extra SRAM cycles per access (0..15)
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   inst_req/addr -> inst_rdata/ack  fetch master (read only)
//   data_req/we/be/addr/wdata -> data_rdata/ack  load/store master
//   mem_ce/we/be/addr/wdata, mem_rdata  shared SRAM port (outputs registered)
//   stall_req                      combinational pipeline stall request
// Configuration:
//   ARB_ROUND_ROBIN_EN  when defined, contended grants alternate between the
//                       masters; otherwise data always wins.

module sram_arbiter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ack,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ack,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_req
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       gnt_data;   // owner of the access in flight: 1 = data, 0 = inst
  logic       pick_data;  // grant decision for the current IDLE cycle
  logic       any_req;

  assign any_req   = inst_req | data_req;
  assign stall_req = (inst_req & ~inst_ack) | (data_req & ~data_ack);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_data;  // 1 when the most recent grant went to data

  always_comb begin
    pick_data = data_req;
    if (inst_req && data_req) begin
      pick_data = ~last_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_data <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_data <= pick_data;
    end
  end
`else
  always_comb begin
    pick_data = data_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 4'd0;
      gnt_data   <= 1'b0;
      mem_ce     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      inst_rdata <= 32'd0;
      data_rdata <= 32'd0;
      inst_ack   <= 1'b0;
      data_ack   <= 1'b0;
    end else begin
      inst_ack <= 1'b0;
      data_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            mem_ce   <= 1'b1;
            cnt      <= WS;
            gnt_data <= pick_data;
            if (pick_data) begin
              mem_we    <= data_we;
              mem_be    <= data_be;
              mem_addr  <= {data_addr[31:2], 2'b00};
              mem_wdata <= data_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_be    <= 4'hF;
              mem_addr  <= {inst_addr[31:2], 2'b00};
              mem_wdata <= 32'd0;
            end
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // mem_we still reflects the granted access here, so stores
            // leave the requester's read register untouched.
            if (!mem_we) begin
              if (gnt_data) data_rdata <= mem_rdata;
              else          inst_rdata <= mem_rdata;
            end
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
          end
        end
        DONE: begin
          inst_ack <= ~gnt_data;
          data_ack <= gnt_data;
        end
        default: begin
          mem_ce <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter: WAIT_STATES, default 1, extra SRAM cycles per access (0..15).
REQ-002 SHALL have port: clk  in  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports: inst_req in 1 fetch request; inst_addr in 32 fetch byte address; inst_rdata out 32 fetched word; inst_ack out 1 fetch done.
REQ-005 SHALL have ports: data_req in 1 load/store request; data_we in 1 store; data_be in 4 byte enables; data_addr in 32; data_wdata in 32; data_rdata out 32; data_ack out 1.
REQ-006 SHALL have ports: mem_ce out 1; mem_we out 1; mem_be out 4; mem_addr out 32; mem_wdata out 32; mem_rdata in 32 (single shared SRAM port).
REQ-007 SHALL have port: stall_req  out  1  pipeline stall request.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, DONE plus a wait counter of width 4.
REQ-009 IDLE, no request -> stay IDLE; all mem_* outputs 0.
REQ-010 IDLE, any request sampled at edge k -> grant one requester, register mem_* from that requester, set counter=WAIT_STATES, go ACCESS.
REQ-011 Fixed priority (macro off): data_req beats inst_req when both asserted in IDLE.
REQ-012 Grant to inst: mem_we=0, mem_be=4'hF, mem_wdata=0; grant to data: mem_we=data_we, mem_be=data_be, mem_wdata=data_wdata.
REQ-013 mem_addr SHALL equal granted address with bits [1:0] forced to 0.
REQ-014 ACCESS: mem_* held constant; counter nonzero -> decrement; counter zero -> capture mem_rdata into granted requester's rdata (reads only), go DONE.
REQ-015 mem_ce SHALL be high for exactly WAIT_STATES+1 cycles per access.
REQ-016 DONE: granted requester's ack high for exactly one cycle; mem_* = 0; requests ignored; next state IDLE.
REQ-017 Latency: request sampled at edge k -> ack high in cycle following edge k+WAIT_STATES+2; throughput one access per WAIT_STATES+3 cycles.
REQ-018 Store: data_rdata SHALL keep its previous value.
REQ-019 inst_rdata/data_rdata SHALL hold value until next completed read of same requester.
REQ-020 Request dropped during ACCESS: access completes, ack still pulses.
REQ-021 Request fields sampled only at grant; later changes ignored for that access.
REQ-022 stall_req SHALL be combinational: (inst_req & ~inst_ack) | (data_req & ~data_ack).
REQ-023 Non-granted request SHALL remain pending and be considered at next IDLE.

Reset
REQ-024 rst high at edge -> state IDLE, counter 0, mem_ce/mem_we 0, mem_be/mem_addr/mem_wdata 0, acks 0, rdata regs 0, last-grant = inst.
REQ-025 rst during ACCESS or DONE SHALL abort access with no ack; requester must reissue.
REQ-026 rst has priority over all other transitions.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous inst_req and data_req in IDLE, grant the requester not granted last; last-grant register updated at every grant.
REQ-028 Macro undefined: fixed data priority per REQ-011; no last-grant register.

Verification
REQ-029 WAIT_STATES=1, inst_req, inst_addr=0x00000006, mem_rdata=0x3C011234 -> mem_ce 2 cycles, mem_addr=0x00000004, inst_ack pulse 4 cycles after request edge, inst_rdata=0x3C011234.
REQ-030 Store data_addr=0x80, data_be=4'b0011, data_wdata=0xDEADBEEF -> mem_we=1, mem_be=4'b0011, mem_wdata=0xDEADBEEF, data_ack one cycle, data_rdata unchanged.
REQ-031 inst_req and data_req both held, macro off -> data served first, inst second; stall_req high until second ack.
REQ-032 Same stimulus, ARB_ROUND_ROBIN_EN on, three contended rounds -> grants data, inst, data.
REQ-033 rst asserted in ACCESS cycle -> next cycle mem_ce=0, no ack, state IDLE; reissued request completes normally.
REQ-034 WAIT_STATES=0, back-to-back loads -> one ack per 3 cycles, no request double-served while held through DONE.
